io_serdes_cfg_bridge: RTL and testbench
=======================================

IO_SERDES_CFG_BRIDGE -- requirements
Module: io_serdes_cfg_bridge

Interface
REQ-001 pADDR_WIDTH, 10, downstream DW-address width.
REQ-002 pDATA_WIDTH, 32, data width.
REQ-003 pBASE_SEL, 3'h3, value of byte-address bits [14:12] that selects the serdes window.
REQ-004 pTIMEOUT, 255, downstream wait cycles before an SLVERR response.
REQ-005 axi_clk  in  1  clock; all logic on its posedge.
REQ-006 axi_reset_n  in  1  reset, asynchronous, active-low.
REQ-007 s_awvalid in 1 / s_awaddr in 15 / s_awready out 1: upstream write address, byte address.
REQ-008 s_wvalid in 1 / s_wdata in 32 / s_wstrb in 4 / s_wready out 1: upstream write data.
REQ-009 s_bvalid out 1 / s_bresp out 2 / s_bready in 1: upstream write response.
REQ-010 s_arvalid in 1 / s_araddr in 15 / s_arready out 1: upstream read address.
REQ-011 s_rvalid out 1 / s_rdata out 32 / s_rresp out 2 / s_rready in 1: upstream read data.
REQ-012 m_awvalid out 1 / m_awaddr out pADDR_WIDTH / m_awready in 1: serdes write address, DW address.
REQ-013 m_wvalid out 1 / m_wdata out 32 / m_wstrb out 4 / m_wready in 1: serdes write data.
REQ-014 m_arvalid out 1 / m_araddr out pADDR_WIDTH / m_arready in 1: serdes read address.
REQ-015 m_rvalid in 1 / m_rdata in 32 / m_rready out 1: serdes read data.
REQ-016 cc_ls_enable  out  1  serdes config-port enable.

Function
REQ-017 Three one-entry holding slots (AW, W, AR) shall capture independently, in any order; s_awready, s_wready and s_arready shall equal their slot-empty flags.
REQ-018 The FSM shall have states IDLE, WR_FWD, WR_RSP, RD_FWD and RD_RSP, with one transaction outstanding.
REQ-019 In IDLE, a write is eligible when AW and W are both held and a read when AR is held; if both are eligible, the grant shall go to the type not granted last.
REQ-020 If addr[14:12] != pBASE_SEL, the FSM shall go directly to the RSP state with resp=2'b11 (DECERR) and rdata=0, with no downstream activity.
REQ-021 In WR_FWD: cc_ls_enable=1, m_awvalid=m_wvalid=1, m_awaddr=awaddr[pADDR_WIDTH+1:2], m_wdata/m_wstrb from the W slot; completes in the cycle m_awready&&m_wready=1; then WR_RSP with resp=2'b00.
REQ-022 In RD_FWD phase A: cc_ls_enable=1, m_arvalid=1 until m_arready=1, with m_araddr=araddr[pADDR_WIDTH+1:2].
REQ-023 In RD_FWD phase B (from the next cycle): m_rready=1; m_rdata shall be captured on the first cycle m_rvalid=1; then RD_RSP with resp=2'b00.
REQ-024 The wait counter shall clear on FWD entry, increment each non-completing FWD cycle, and saturate without wrap-around.
REQ-025 When the wait counter reaches pTIMEOUT, all m_* valid/ready outputs shall drop and the FSM shall go to RSP with resp=2'b10 (SLVERR) and rdata=0.
REQ-026 WR_RSP: s_bvalid=1 with s_bresp stable until s_bready=1; on that handshake the AW and W slots clear and the FSM returns to IDLE.
REQ-027 RD_RSP: s_rvalid=1 with s_rdata/s_rresp stable until s_rready=1; on that handshake the AR slot clears and the FSM returns to IDLE.
REQ-028 Empty slots shall keep accepting during another transaction, e.g. AR accepted during WR_FWD.
REQ-029 Minimum latency: write slots full at cycle N -> WR_FWD at N+1 -> s_bvalid at N+2; read: AR held at N -> m_arvalid at N+1 -> m_rready at N+2 -> s_rvalid at N+3.
REQ-030 cc_ls_enable shall be 1 only in WR_FWD and RD_FWD.

Reset
REQ-031 While axi_reset_n=0: state IDLE, slots empty, last grant = read, all outputs 0 including s_*ready.
REQ-032 s_awready/s_wready/s_arready shall be 1 in the first cycle after reset release.
REQ-033 Reset mid-transaction shall abort the transaction with no response and drop all m_* valids in the same cycle.

Structure
REQ-034 State encodings, RESP_OKAY/RESP_SLVERR/RESP_DECERR and the error rdata value shall reside in the shared package fsic_cfg_pkg.
REQ-035 The three slots shall be instances of one sub-module, io_serdes_cfg_slot: a valid/data register with load and clear.

Verification
REQ-036 Write awaddr=0x3000, wdata=0x3, wstrb=0xF, downstream ready immediate -> m_awaddr=0x000, cc_ls_enable pulses 1 cycle, bresp=00 two cycles after capture.
REQ-037 W presented 3 cycles before AW -> no downstream activity until AW is captured, then a single combined m_aw/m_w beat.
REQ-038 Read araddr=0x3000, m_rvalid=1 constant, m_rdata=0x2 -> s_rdata=0x2, rresp=00, s_rvalid at capture+3.
REQ-039 Write to 0x1004 -> bresp=11, cc_ls_enable never 1; read of 0x1004 -> rresp=11, rdata=0.
REQ-040 m_awready held 0, pTIMEOUT=255 -> bresp=10 after 255 WR_FWD cycles; m_awvalid drops the same cycle.
REQ-041 Write and read pending simultaneously twice -> grants W,R,W,R; assert reset during RD_FWD -> no s_rvalid, all outputs 0.

Source files
------------

// File: rtl/fsic_cfg_pkg.sv
// Shared definitions for the fsic configuration bridges: FSM state
// encodings, AXI response codes, the error read-data value and the
// address-window decode helper.
package fsic_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_FWD = 3'd1,
    ST_WR_RSP = 3'd2,
    ST_RD_FWD = 3'd3,
    ST_RD_RSP = 3'd4
  } cfg_state_t;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [31:0] ERR_RDATA   = 32'h0000_0000;

  // True when a 15-bit byte address falls inside the selected 4 KB window.
  function automatic logic hit_window(input logic [14:0] addr, input logic [2:0] sel);
    return (addr[14:12] == sel);
  endfunction

endpackage

// File: rtl/io_serdes_cfg_slot.sv
// One-entry holding slot: a valid flag plus a data register. The flag is
// control state and is reset; the payload only matters while valid is set.
module io_serdes_cfg_slot #(
  parameter int W = 8
) (
  input  logic         axi_clk,
  input  logic         axi_reset_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] data
);

  // Valid flag: set on load, dropped on clear (they never coincide since
  // load is only offered while the slot is empty).
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n)  valid <= 1'b0;
    else if (clear)    valid <= 1'b0;
    else if (load)     valid <= 1'b1;
  end

  // Payload register, captured together with the valid flag.
  always_ff @(posedge axi_clk) begin
    if (load) data <= din;
  end

endmodule

// File: rtl/io_serdes_cfg_bridge.sv
// Bridges an upstream AXI-Lite style config port onto the serdes config
// port. Holds one AW, W and AR beat each, arbitrates reads vs. writes
// round-robin, decodes the serdes window and times out a stuck downstream.
module io_serdes_cfg_bridge
  import fsic_cfg_pkg::*;
#(
  parameter int         pADDR_WIDTH = 10,
  parameter int         pDATA_WIDTH = 32,
  parameter logic [2:0] pBASE_SEL   = 3'h3,
  parameter int         pTIMEOUT    = 255
) (
  input  logic                     axi_clk,
  input  logic                     axi_reset_n,
  input  logic                     s_awvalid,
  input  logic [14:0]              s_awaddr,
  output logic                     s_awready,
  input  logic                     s_wvalid,
  input  logic [pDATA_WIDTH-1:0]   s_wdata,
  input  logic [pDATA_WIDTH/8-1:0] s_wstrb,
  output logic                     s_wready,
  output logic                     s_bvalid,
  output logic [1:0]               s_bresp,
  input  logic                     s_bready,
  input  logic                     s_arvalid,
  input  logic [14:0]              s_araddr,
  output logic                     s_arready,
  output logic                     s_rvalid,
  output logic [pDATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]               s_rresp,
  input  logic                     s_rready,
  output logic                     m_awvalid,
  output logic [pADDR_WIDTH-1:0]   m_awaddr,
  input  logic                     m_awready,
  output logic                     m_wvalid,
  output logic [pDATA_WIDTH-1:0]   m_wdata,
  output logic [pDATA_WIDTH/8-1:0] m_wstrb,
  input  logic                     m_wready,
  output logic                     m_arvalid,
  output logic [pADDR_WIDTH-1:0]   m_araddr,
  input  logic                     m_arready,
  input  logic                     m_rvalid,
  input  logic [pDATA_WIDTH-1:0]   m_rdata,
  output logic                     m_rready,
  output logic                     cc_ls_enable
);

  localparam int SW    = pDATA_WIDTH/8;
  localparam int CNT_W = $clog2(pTIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(pTIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                   aw_vld, w_vld, ar_vld;
  logic [14:0]            aw_addr, ar_addr;
  logic [pDATA_WIDTH-1:0] w_data;
  logic [SW-1:0]          w_strb;
  logic                   aw_clr, w_clr, ar_clr;

  cfg_state_t             state_q, state_d;
  logic                   last_rd_q, last_rd_d;
  logic                   ar_done_q, ar_done_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             resp_q, resp_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                   timeout, pick_rd;

  // Address offset bits below the DW boundary carry no meaning downstream.
  logic unused_addr;
  assign unused_addr = ^{aw_addr, ar_addr};

  // Readiness mirrors slot emptiness, held low while reset is asserted.
  assign s_awready = axi_reset_n & ~aw_vld;
  assign s_wready  = axi_reset_n & ~w_vld;
  assign s_arready = axi_reset_n & ~ar_vld;

  io_serdes_cfg_slot #(.W(15)) u_aw_slot (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .load(s_awvalid & s_awready),
    .clear(aw_clr), .din(s_awaddr), .valid(aw_vld), .data(aw_addr));

  io_serdes_cfg_slot #(.W(pDATA_WIDTH + SW)) u_w_slot (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .load(s_wvalid & s_wready),
    .clear(w_clr), .din({s_wstrb, s_wdata}), .valid(w_vld), .data({w_strb, w_data}));

  io_serdes_cfg_slot #(.W(15)) u_ar_slot (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .load(s_arvalid & s_arready),
    .clear(ar_clr), .din(s_araddr), .valid(ar_vld), .data(ar_addr));

  // Control state: FSM, arbitration history, read phase, wait counter, response.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q   <= ST_IDLE;
      last_rd_q <= 1'b1;
      ar_done_q <= 1'b0;
      cnt_q     <= '0;
      resp_q    <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      ar_done_q <= ar_done_d;
      cnt_q     <= cnt_d;
      resp_q    <= resp_d;
    end
  end

  // Returned read data; only visible through s_rdata while in RD_RSP.
  always_ff @(posedge axi_clk) begin
    rdata_q <= rdata_d;
  end

  // Next-state and output decode; downstream outputs fall away once the
  // wait counter has reached the timeout limit.
  always_comb begin
    state_d      = state_q;
    last_rd_d    = last_rd_q;
    ar_done_d    = ar_done_q;
    cnt_d        = cnt_q;
    resp_d       = resp_q;
    rdata_d      = rdata_q;
    aw_clr       = 1'b0;
    w_clr        = 1'b0;
    ar_clr       = 1'b0;
    cc_ls_enable = 1'b0;
    m_awvalid    = 1'b0;
    m_awaddr     = '0;
    m_wvalid     = 1'b0;
    m_wdata      = '0;
    m_wstrb      = '0;
    m_arvalid    = 1'b0;
    m_araddr     = '0;
    m_rready     = 1'b0;
    s_bvalid     = 1'b0;
    s_bresp      = 2'b00;
    s_rvalid     = 1'b0;
    s_rresp      = 2'b00;
    s_rdata      = '0;
    timeout      = (cnt_q == CNT_MAX);
    pick_rd      = ar_vld & (~(aw_vld & w_vld) | ~last_rd_q);
    unique case (state_q)
      ST_IDLE: begin
        if (pick_rd) begin
          last_rd_d = 1'b1;
          cnt_d     = '0;
          ar_done_d = 1'b0;
          if (hit_window(ar_addr, pBASE_SEL)) begin
            state_d = ST_RD_FWD;
          end else begin
            state_d = ST_RD_RSP;
            resp_d  = RESP_DECERR;
            rdata_d = pDATA_WIDTH'(ERR_RDATA);
          end
        end else if (aw_vld && w_vld) begin
          last_rd_d = 1'b0;
          cnt_d     = '0;
          if (hit_window(aw_addr, pBASE_SEL)) begin
            state_d = ST_WR_FWD;
          end else begin
            state_d = ST_WR_RSP;
            resp_d  = RESP_DECERR;
          end
        end
      end
      ST_WR_FWD: begin
        cc_ls_enable = 1'b1;
        if (timeout) begin
          state_d = ST_WR_RSP;
          resp_d  = RESP_SLVERR;
        end else begin
          m_awvalid = 1'b1;
          m_wvalid  = 1'b1;
          m_awaddr  = aw_addr[pADDR_WIDTH+1:2];
          m_wdata   = w_data;
          m_wstrb   = w_strb;
          if (m_awready && m_wready) begin
            state_d = ST_WR_RSP;
            resp_d  = RESP_OKAY;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ST_RD_FWD: begin
        cc_ls_enable = 1'b1;
        if (timeout) begin
          state_d = ST_RD_RSP;
          resp_d  = RESP_SLVERR;
          rdata_d = pDATA_WIDTH'(ERR_RDATA);
        end else if (!ar_done_q) begin
          m_arvalid = 1'b1;
          m_araddr  = ar_addr[pADDR_WIDTH+1:2];
          if (m_arready) ar_done_d = 1'b1;
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          m_rready = 1'b1;
          if (m_rvalid) begin
            state_d = ST_RD_RSP;
            resp_d  = RESP_OKAY;
            rdata_d = m_rdata;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ST_WR_RSP: begin
        s_bvalid = 1'b1;
        s_bresp  = resp_q;
        if (s_bready) begin
          aw_clr  = 1'b1;
          w_clr   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RD_RSP: begin
        s_rvalid = 1'b1;
        s_rresp  = resp_q;
        s_rdata  = rdata_q;
        if (s_rready) begin
          ar_clr  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_io_serdes_cfg_bridge.sv
// Directed bench for io_serdes_cfg_bridge: reset, forwarded write/read,
// out-of-order W/AW, decode errors, arbitration, timeout, mid-read reset.
module tb_io_serdes_cfg_bridge;

  logic        axi_clk = 1'b0;
  logic        axi_reset_n;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [14:0] s_awaddr, s_araddr;
  logic [31:0] s_wdata, s_rdata, m_wdata, m_rdata;
  logic [3:0]  s_wstrb, m_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_arvalid, m_arready;
  logic        m_rvalid, m_rready, cc_ls_enable;
  logic [9:0]  m_awaddr, m_araddr;

  int total = 0;
  int bad   = 0;
  int n_aw, n_g;
  logic prev_aw, got;
  logic [7:0] glog [4];

  always #5 axi_clk = ~axi_clk;

  io_serdes_cfg_bridge dut (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready),
    .cc_ls_enable(cc_ls_enable));

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    axi_reset_n = 1'b0;
    s_awvalid = 0; s_awaddr = '0; s_wvalid = 0; s_wdata = '0; s_wstrb = '0;
    s_arvalid = 0; s_araddr = '0; s_bready = 1; s_rready = 1;
    m_awready = 1; m_wready = 1; m_arready = 1; m_rvalid = 0; m_rdata = '0;
    n_g = 0;

    // Reset: everything low, including the upstream readies.
    tick(); tick();
    chk("rst_awready", s_awready, 0);
    chk("rst_wready", s_wready, 0);
    chk("rst_arready", s_arready, 0);
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_cc", cc_ls_enable, 0);
    chk("rst_bvalid", s_bvalid, 0);
    axi_reset_n = 1'b1;
    #1;
    chk("rel_awready", s_awready, 1);
    chk("rel_wready", s_wready, 1);
    chk("rel_arready", s_arready, 1);

    // Forwarded write to 0x3000, downstream ready immediately.
    tick();
    s_awvalid = 1; s_awaddr = 15'h3000; s_wvalid = 1; s_wdata = 32'h3; s_wstrb = 4'hF;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    chk("w1_awready_full", s_awready, 0);
    chk("w1_cc_idle", cc_ls_enable, 0);
    tick();
    chk("w1_cc", cc_ls_enable, 1);
    chk("w1_m_awvalid", m_awvalid, 1);
    chk("w1_m_wvalid", m_wvalid, 1);
    chk("w1_m_awaddr", m_awaddr, 10'h000);
    chk("w1_m_wdata", m_wdata, 32'h3);
    chk("w1_m_wstrb", m_wstrb, 4'hF);
    tick();
    chk("w1_cc_off", cc_ls_enable, 0);
    chk("w1_bvalid", s_bvalid, 1);
    chk("w1_bresp", s_bresp, 2'b00);
    tick();
    chk("w1_bvalid_done", s_bvalid, 0);
    chk("w1_awready_free", s_awready, 1);

    // W arrives three cycles before AW: nothing moves downstream meanwhile.
    s_wvalid = 1; s_wdata = 32'h55; s_wstrb = 4'h3;
    tick();
    s_wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("w2_no_awvalid", m_awvalid, 0);
      chk("w2_no_cc", cc_ls_enable, 0);
      tick();
    end
    chk("w2_wready_full", s_wready, 0);
    s_awvalid = 1; s_awaddr = 15'h3008;
    tick();
    s_awvalid = 0;
    chk("w2_idle_cycle", m_awvalid, 0);
    tick();
    chk("w2_m_awvalid", m_awvalid, 1);
    chk("w2_m_wvalid", m_wvalid, 1);
    chk("w2_m_awaddr", m_awaddr, 10'h002);
    chk("w2_m_wdata", m_wdata, 32'h55);
    chk("w2_m_wstrb", m_wstrb, 4'h3);
    tick();
    chk("w2_single_beat", m_awvalid, 0);
    chk("w2_bresp", s_bresp, 2'b00);
    chk("w2_bvalid", s_bvalid, 1);
    tick();

    // Forwarded read of 0x3000 with m_rvalid held high.
    m_rvalid = 1; m_rdata = 32'h2;
    s_arvalid = 1; s_araddr = 15'h3000;
    tick();
    s_arvalid = 0;
    chk("r1_arready_full", s_arready, 0);
    chk("r1_no_arvalid", m_arvalid, 0);
    tick();
    chk("r1_m_arvalid", m_arvalid, 1);
    chk("r1_m_araddr", m_araddr, 10'h000);
    chk("r1_cc", cc_ls_enable, 1);
    tick();
    chk("r1_m_rready", m_rready, 1);
    chk("r1_arvalid_off", m_arvalid, 0);
    tick();
    chk("r1_rvalid", s_rvalid, 1);
    chk("r1_rdata", s_rdata, 32'h2);
    chk("r1_rresp", s_rresp, 2'b00);
    chk("r1_cc_off", cc_ls_enable, 0);
    tick();
    chk("r1_rvalid_done", s_rvalid, 0);

    // Outside the window: DECERR, no downstream activity.
    s_awvalid = 1; s_awaddr = 15'h1004; s_wvalid = 1; s_wdata = 32'hDEAD; s_wstrb = 4'hF;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    chk("de_w_cc_idle", cc_ls_enable, 0);
    tick();
    chk("de_w_bvalid", s_bvalid, 1);
    chk("de_w_bresp", s_bresp, 2'b11);
    chk("de_w_cc", cc_ls_enable, 0);
    chk("de_w_m_awvalid", m_awvalid, 0);
    tick();
    s_arvalid = 1; s_araddr = 15'h1004;
    tick();
    s_arvalid = 0;
    tick();
    chk("de_r_rvalid", s_rvalid, 1);
    chk("de_r_rresp", s_rresp, 2'b11);
    chk("de_r_rdata", s_rdata, 32'h0);
    chk("de_r_m_arvalid", m_arvalid, 0);
    tick();

    // Write and read pending together, twice: grants alternate W,R,W,R.
    m_rdata = 32'hA5;
    for (int r = 0; r < 2; r++) begin
      s_awvalid = 1; s_awaddr = 15'h300C; s_wvalid = 1; s_wdata = 32'h11; s_wstrb = 4'hF;
      s_arvalid = 1; s_araddr = 15'h3010;
      tick();
      s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (m_awvalid && n_g < 4) begin glog[n_g] = 8'h57; n_g++; end
        if (m_arvalid && n_g < 4) begin glog[n_g] = 8'h52; n_g++; end
      end
    end
    chk("arb_count", n_g, 4);
    chk("arb_g0", glog[0], 8'h57);
    chk("arb_g1", glog[1], 8'h52);
    chk("arb_g2", glog[2], 8'h57);
    chk("arb_g3", glog[3], 8'h52);

    // Stuck m_awready: SLVERR after 255 forwarding cycles.
    m_awready = 0;
    s_awvalid = 1; s_awaddr = 15'h3000; s_wvalid = 1; s_wdata = 32'h7; s_wstrb = 4'hF;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    n_aw = 0; prev_aw = 1; got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      tick();
      if (s_bvalid) got = 1;
      else begin
        prev_aw = m_awvalid;
        if (m_awvalid) n_aw++;
      end
    end
    chk("to_bvalid", got, 1);
    chk("to_fwd_cycles", n_aw, 255);
    chk("to_awvalid_drop", prev_aw, 0);
    chk("to_bresp", s_bresp, 2'b10);
    tick();
    m_awready = 1;

    // Reset asserted during RD_FWD aborts the read silently.
    m_arready = 0;
    s_arvalid = 1; s_araddr = 15'h3000;
    tick();
    s_arvalid = 0;
    tick();
    chk("rr_m_arvalid", m_arvalid, 1);
    chk("rr_cc", cc_ls_enable, 1);
    axi_reset_n = 1'b0;
    #1;
    chk("rr_arvalid_drop", m_arvalid, 0);
    chk("rr_cc_drop", cc_ls_enable, 0);
    chk("rr_arready_low", s_arready, 0);
    chk("rr_rvalid_low", s_rvalid, 0);
    tick(); tick();
    axi_reset_n = 1'b1;
    m_arready = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_no_rvalid", s_rvalid, 0);
      chk("rr_no_arvalid", m_arvalid, 0);
    end
    chk("rr_arready_free", s_arready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
